// File: rtl/wb_uart_tx.sv
// Wishbone B4 classic slave UART transmitter: TX FIFO feeding an 8N1 shifter with programmable baud divisor.
// Optional even-parity bit is compiled in with `define WB_UART_TX_PARITY_EN (8E1, 11-bit frame).
module wb_uart_tx #(
    parameter int FIFO_DEPTH      = 16,
    parameter int DEFAULT_DIVISOR = 868
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    output logic        ack_o,
    output logic        err_o,
    output logic        rty_o,
    output logic        tx_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3
`ifdef WB_UART_TX_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [AW:0] r_wr_ptr, r_rd_ptr, w_level;
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [7:0]  w_fifo_dout;
    logic        w_full, w_empty, w_push, w_pop;
    logic        r_ack, w_ack_nxt;
    logic [31:0] r_dat, w_rdata, w_status;
    logic [15:0] r_div, r_bit_div, r_cnt, w_div_lanes, w_div_new, w_level16;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        w_req, w_stall, w_commit, w_div_wr, w_bit_end, w_tx, w_busy, w_par_flag;
    logic        w_unused;
`ifdef WB_UART_TX_PARITY_EN
    logic        r_par;
    assign w_par_flag = 1'b1;
`else
    assign w_par_flag = 1'b0;
`endif

    assign w_unused = ^{adr_i[31:4], adr_i[1:0], dat_i[31:16], sel_i[3:2]};

    assign w_level     = r_wr_ptr - r_rd_ptr;
    assign w_full      = (w_level == DEPTH_L);
    assign w_empty     = (w_level == '0);
    assign w_level16   = 16'(w_level);
    assign w_fifo_dout = r_mem[r_rd_ptr[AW-1:0]];

    // Stall is decided on registered FIFO state; the push itself commits on the ack cycle.
    assign w_req     = cyc_i & stb_i;
    assign w_stall   = we_i & (adr_i[3:2] == 2'd0) & sel_i[0] & w_full;
    assign w_ack_nxt = w_req & ~r_ack & ~w_stall;
    assign w_commit  = w_req & r_ack & we_i;
    assign w_push    = w_commit & (adr_i[3:2] == 2'd0) & sel_i[0];
    assign w_div_wr  = w_commit & (adr_i[3:2] == 2'd2);

    assign w_div_lanes = {sel_i[1] ? dat_i[15:8] : r_div[15:8],
                          sel_i[0] ? dat_i[7:0]  : r_div[7:0]};
    assign w_div_new   = (w_div_lanes == 16'd0) ? 16'd1 : w_div_lanes;

    assign w_status = {16'd0, w_level16[7:0], 4'd0, w_par_flag, w_busy, w_empty, w_full};

    always_comb begin
        w_rdata = '0;
        case (adr_i[3:2])
            2'd1:    w_rdata = w_status;
            2'd2:    w_rdata = {16'd0, r_div};
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
            r_div <= 16'(DEFAULT_DIVISOR);
        end else begin
            r_ack <= w_ack_nxt;
            r_dat <= (w_ack_nxt & ~we_i) ? w_rdata : '0;
            if (w_div_wr)
                r_div <= w_div_new;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= dat_i[7:0];
    end

    assign w_bit_end = (r_cnt == 16'd0);
    assign w_pop     = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_pop) w_state_nxt = S_START;
            S_START:  if (w_bit_end) w_state_nxt = S_DATA;
            S_DATA:
                if (w_bit_end && r_bit_idx == 3'd7) begin
`ifdef WB_UART_TX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
`ifdef WB_UART_TX_PARITY_EN
            S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
`endif
            S_STOP:   if (w_bit_end) w_state_nxt = w_pop ? S_START : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_tx   = 1'b1;
        w_busy = (r_state != S_IDLE);
        case (r_state)
            S_START:  w_tx = 1'b0;
            S_DATA:   w_tx = r_shift[0];
`ifdef WB_UART_TX_PARITY_EN
            S_PARITY: w_tx = r_par;
`endif
            default:  w_tx = 1'b1;
        endcase
    end

    // Divisor is captured per frame so a mid-frame DIVISOR write only affects later frames.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt     <= '0;
            r_bit_div <= 16'd1;
            r_bit_idx <= '0;
            r_shift   <= '0;
`ifdef WB_UART_TX_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else if (w_pop) begin
            r_shift   <= w_fifo_dout;
            r_bit_div <= r_div;
            r_cnt     <= r_div - 16'd1;
            r_bit_idx <= '0;
`ifdef WB_UART_TX_PARITY_EN
            r_par     <= ^w_fifo_dout;
`endif
        end else if (r_state != S_IDLE) begin
            if (w_bit_end) begin
                r_cnt <= r_bit_div - 16'd1;
                if (r_state == S_DATA) begin
                    r_shift   <= r_shift >> 1;
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
            end else begin
                r_cnt <= r_cnt - 16'd1;
            end
        end
    end

    assign ack_o = r_ack;
    assign dat_o = r_dat;
    assign err_o = 1'b0;
    assign rty_o = 1'b0;
    assign tx_o  = w_tx;

endmodule
